wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/cpu_defs.sv | 37 +++
 rtl/load_ext.sv | 28 ++
 rtl/wb_regfile.sv | 102 ++++++++++
 tb/tb_wb_regfile.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared CPU decode constants and the write-back source classification.
package cpu_defs;

    localparam logic [5:0] LW         = 6'b100011;
    localparam logic [5:0] LB         = 6'b100000;
    localparam logic [5:0] LBU        = 6'b100100;
    localparam logic [5:0] LH         = 6'b100001;
    localparam logic [5:0] LHU        = 6'b100101;
    localparam logic [5:0] JAL        = 6'b000011;
    localparam logic [5:0] SPECIAL    = 6'b000000;
    localparam logic [5:0] JALR_FUNCT = 6'b001001;

    typedef enum logic [2:0] {
        WB_ALU,
        WB_LW,
        WB_LB,
        WB_LBU,
        WB_LH,
        WB_LHU,
        WB_LINK
    } wb_sel_e;

    // Bubbles (all-zero word) fall through to WB_ALU; the write enable masks them.
    function automatic wb_sel_e classify(input logic [31:0] ins);
        case (ins[31:26])
            LW:      return WB_LW;
            LB:      return WB_LB;
            LBU:     return WB_LBU;
            LH:      return WB_LH;
            LHU:     return WB_LHU;
            JAL:     return WB_LINK;
            SPECIAL: return (ins[5:0] == JALR_FUNCT) ? WB_LINK : WB_ALU;
            default: return WB_ALU;
        endcase
    endfunction

endpackage

// File: rtl/load_ext.sv
// Load extender: selects the byte/halfword addressed by the low address bits
// and sign- or zero-extends it; word loads and non-loads pass the raw word.
module load_ext
    import cpu_defs::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  wb_sel_e     sel_i,
    output logic [31:0] value_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v  = rdata_i[{offset_i, 3'b000} +: 8];
        half_v  = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        value_o = rdata_i;
        case (sel_i)
            WB_LB:   value_o = {{24{byte_v[7]}}, byte_v};
            WB_LBU:  value_o = {24'd0, byte_v};
            WB_LH:   value_o = {{16{half_v[15]}}, half_v};
            WB_LHU:  value_o = {16'd0, half_v};
            default: value_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage plus 32x32 GPR file with write-first bypass to the D-stage
// read ports, a registered trace of the last committed write and a retire counter.
module wb_regfile
    import cpu_defs::*;
#(
    parameter logic [31:0] LINK_OFFSET = 32'd8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] W_ReadData,
    input  logic [31:0] W_ALUData,
    input  logic [4:0]  W_TargetReg,
    input  logic [2:0]  W_T_new,
    input  logic [31:0] W_Ins,
    input  logic [31:0] W_PCAddr,
    input  logic [4:0]  D_Rs,
    input  logic [4:0]  D_Rt,
    output logic [31:0] D_RsData,
    output logic [31:0] D_RtData,
    output logic [31:0] W_FwdData,
    output logic        grf_we,
    output logic [4:0]  grf_addr,
    output logic [31:0] grf_wdata,
    output logic [31:0] grf_pc,
    output logic [31:0] retire_cnt
);

    wb_sel_e           sel;
    logic [31:0]       load_val;
    logic              valid;
    logic              we;
    logic [31:0][31:0] gpr_q;
    logic [31:0]       retire_cnt_q, retire_cnt_d;
    logic              grf_we_q;
    logic [4:0]        grf_addr_q;
    logic [31:0]       grf_wdata_q, grf_pc_q;

    assign sel   = classify(W_Ins);
    assign valid = (W_Ins != 32'd0);
    // Reset masks the write so neither the array nor the bypass sees it.
    assign we    = !reset && valid && (W_TargetReg != 5'd0);

    load_ext u_load_ext (
        .rdata_i  (W_ReadData),
        .offset_i (W_ALUData[1:0]),
        .sel_i    (sel),
        .value_o  (load_val)
    );

    always_comb begin
        W_FwdData = W_ALUData;
        case (sel)
            WB_LINK: W_FwdData = W_PCAddr + LINK_OFFSET;
            WB_ALU:  W_FwdData = W_ALUData;
            default: W_FwdData = load_val;
        endcase
    end

    always_comb begin
        D_RsData = 32'd0;
        D_RtData = 32'd0;
        if (D_Rs != 5'd0)
            D_RsData = (we && D_Rs == W_TargetReg) ? W_FwdData : gpr_q[D_Rs];
        if (D_Rt != 5'd0)
            D_RtData = (we && D_Rt == W_TargetReg) ? W_FwdData : gpr_q[D_Rt];
    end

    assign retire_cnt_d = valid ? retire_cnt_q + 32'd1 : retire_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            gpr_q        <= '0;
            retire_cnt_q <= 32'd0;
            grf_we_q     <= 1'b0;
            grf_addr_q   <= 5'd0;
            grf_wdata_q  <= 32'd0;
            grf_pc_q     <= 32'd0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
            grf_we_q     <= we;
            if (we) begin
                gpr_q[W_TargetReg] <= W_FwdData;
                grf_addr_q         <= W_TargetReg;
                grf_wdata_q        <= W_FwdData;
                grf_pc_q           <= W_PCAddr;
            end
        end
    end

    // Every legal instruction has its result ready by write-back.
    always_ff @(posedge clk) begin
        if (!reset && valid)
            assert (W_T_new == 3'd0);
    end

    assign grf_we     = grf_we_q;
    assign grf_addr   = grf_addr_q;
    assign grf_wdata  = grf_wdata_q;
    assign grf_pc     = grf_pc_q;
    assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed and randomized bench for wb_regfile against a behavioural model
// of the register file, trace port and retire counter.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] W_ReadData, W_ALUData, W_Ins, W_PCAddr;
    logic [4:0]  W_TargetReg, D_Rs, D_Rt;
    logic [2:0]  W_T_new;
    logic [31:0] D_RsData, D_RtData, W_FwdData, grf_wdata, grf_pc, retire_cnt;
    logic        grf_we;
    logic [4:0]  grf_addr;

    wb_regfile #(.LINK_OFFSET(32'd8)) dut (
        .clk(clk), .reset(reset),
        .W_ReadData(W_ReadData), .W_ALUData(W_ALUData), .W_TargetReg(W_TargetReg),
        .W_T_new(W_T_new), .W_Ins(W_Ins), .W_PCAddr(W_PCAddr),
        .D_Rs(D_Rs), .D_Rt(D_Rt), .D_RsData(D_RsData), .D_RtData(D_RtData),
        .W_FwdData(W_FwdData), .grf_we(grf_we), .grf_addr(grf_addr),
        .grf_wdata(grf_wdata), .grf_pc(grf_pc), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    localparam int K_BUB = 0, K_LW = 1, K_LB = 2, K_LBU = 3, K_LH = 4, K_LHU = 5;
    localparam int K_JAL = 6, K_JALR = 7, K_ADDIU = 8, K_ADDU = 9;

    int          total = 0;
    int          passed = 0;
    int          cur_kind = K_BUB;
    logic [31:0] m_gpr [32];
    logic [31:0] m_cnt, m_wdata, m_pc;
    logic        m_we;
    logic [4:0]  m_addr;

    function automatic logic [31:0] make_ins(input int k, input logic [31:0] r);
        case (k)
            K_LW:    return {6'b100011, r[25:0]};
            K_LB:    return {6'b100000, r[25:0]};
            K_LBU:   return {6'b100100, r[25:0]};
            K_LH:    return {6'b100001, r[25:0]};
            K_LHU:   return {6'b100101, r[25:0]};
            K_JAL:   return {6'b000011, r[25:0]};
            K_JALR:  return {6'b000000, r[25:6], 6'b001001};
            K_ADDIU: return {6'b001001, r[25:0]};
            K_ADDU:  return {6'b000000, r[25:6], 6'b100001};
            default: return 32'd0;
        endcase
    endfunction

    // Expected write value from the load/link/ALU rules using plain arithmetic.
    function automatic logic [31:0] exp_val(input int k, input logic [31:0] rd,
                                            input logic [31:0] alu, input logic [31:0] pc);
        logic [31:0] b, h;
        b = (rd >> (8 * alu[1:0])) & 32'hFF;
        h = alu[1] ? (rd >> 16) : (rd & 32'hFFFF);
        case (k)
            K_LW:           return rd;
            K_LB:           return (b >= 32'd128) ? (b | 32'hFFFFFF00) : b;
            K_LBU:          return b;
            K_LH:           return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
            K_LHU:          return h;
            K_JAL, K_JALR:  return pc + 32'd8;
            default:        return alu;
        endcase
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (!reset && cur_kind != K_BUB && a == W_TargetReg)
            return exp_val(cur_kind, W_ReadData, W_ALUData, W_PCAddr);
        return m_gpr[a];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic set_in(input int k, input logic [31:0] rd, input logic [31:0] alu,
                          input logic [4:0] tgt, input logic [31:0] pc,
                          input logic [4:0] rs, input logic [4:0] rt, input logic rst);
        logic [31:0] r;
        r = $urandom();
        cur_kind    = k;
        W_Ins       = make_ins(k, r);
        W_ReadData  = rd;
        W_ALUData   = alu;
        W_TargetReg = tgt;
        W_PCAddr    = pc;
        W_T_new     = 3'd0;
        D_Rs        = rs;
        D_Rt        = rt;
        reset       = rst;
    endtask

    task automatic pre_check(input string tag);
        #1;
        check({tag, "_fwd"}, W_FwdData, exp_val(cur_kind, W_ReadData, W_ALUData, W_PCAddr));
        check({tag, "_rs"}, D_RsData, exp_read(D_Rs));
        check({tag, "_rt"}, D_RtData, exp_read(D_Rt));
    endtask

    task automatic tick(input string tag);
        logic [31:0] v;
        @(posedge clk);
        v = exp_val(cur_kind, W_ReadData, W_ALUData, W_PCAddr);
        if (reset) begin
            for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
            m_cnt = 32'd0; m_we = 1'b0; m_addr = 5'd0; m_wdata = 32'd0; m_pc = 32'd0;
        end else begin
            if (cur_kind != K_BUB) m_cnt = m_cnt + 32'd1;
            if (cur_kind != K_BUB && W_TargetReg != 5'd0) begin
                m_gpr[W_TargetReg] = v;
                m_we = 1'b1; m_addr = W_TargetReg; m_wdata = v; m_pc = W_PCAddr;
            end else begin
                m_we = 1'b0;
            end
        end
        #1;
        check({tag, "_cnt"}, retire_cnt, m_cnt);
        check({tag, "_we"}, {31'd0, grf_we}, {31'd0, m_we});
        check({tag, "_addr"}, {27'd0, grf_addr}, {27'd0, m_addr});
        check({tag, "_wdata"}, grf_wdata, m_wdata);
        check({tag, "_pc"}, grf_pc, m_pc);
    endtask

    task automatic cycle(input string tag);
        pre_check(tag);
        tick(tag);
    endtask

    initial begin
        int k;
        logic [4:0] tgt, rs, rt;

        set_in(K_BUB, 32'd0, 32'd0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1);
        tick("rst0");
        cycle("rst1");
        for (int r = 1; r < 32; r += 10) begin
            D_Rs = 5'(r);
            #1 check("rst_read", D_RsData, 32'd0);
        end

        // Valid write to reg 7 while reset is held: nothing commits or bypasses.
        set_in(K_ADDU, 32'd0, 32'h0000_0055, 5'd7, 32'h100, 5'd7, 5'd7, 1'b1);
        #1 check("rstwr_bypass", D_RsData, 32'd0);
        tick("rstwr");
        set_in(K_BUB, 32'd0, 32'd0, 5'd0, 32'd0, 5'd7, 5'd0, 1'b0);
        #1 check("rstwr_gpr7", D_RsData, 32'd0);
        check("rstwr_cnt", retire_cnt, 32'd0);

        set_in(K_LB, 32'h80FF7F01, 32'h0000_1002, 5'd3, 32'h200, 5'd3, 5'd0, 1'b0);
        #1 check("lb_const", W_FwdData, 32'hFFFFFFFF);
        cycle("lb");
        set_in(K_LBU, 32'h80FF7F01, 32'h0000_1002, 5'd4, 32'h204, 5'd3, 5'd4, 1'b0);
        #1 check("lbu_const", W_FwdData, 32'h000000FF);
        cycle("lbu");
        set_in(K_LH, 32'h80FF7F01, 32'h0000_1002, 5'd6, 32'h208, 5'd6, 5'd4, 1'b0);
        #1 check("lh_const", W_FwdData, 32'hFFFF80FF);
        cycle("lh");

        set_in(K_ADDU, 32'd0, 32'h12345678, 5'd5, 32'h20C, 5'd5, 5'd3, 1'b0);
        #1 check("bypass_const", D_RsData, 32'h12345678);
        cycle("bypass");

        set_in(K_JAL, 32'd0, 32'h0, 5'd31, 32'h00003000, 5'd31, 5'd5, 1'b0);
        cycle("jal");
        set_in(K_BUB, 32'd0, 32'd0, 5'd0, 32'd0, 5'd31, 5'd0, 1'b0);
        #1 check("jal_gpr31", D_RsData, 32'h00003008);
        check("jal_grf_pc", grf_pc, 32'h00003000);
        check("jal_grf_we", {31'd0, grf_we}, 32'd1);
        cycle("jal_bub");

        set_in(K_ADDU, 32'd0, 32'hDEADBEEF, 5'd0, 32'h300, 5'd0, 5'd0, 1'b0);
        #1 check("r0_read", D_RsData, 32'd0);
        cycle("r0");
        check("r0_grf_we", {31'd0, grf_we}, 32'd0);

        // Counter wrap: preload through the register itself, then bubbles/valid.
        @(negedge clk);
        force dut.retire_cnt_q = 32'hFFFFFFFF;
        #1 release dut.retire_cnt_q;
        m_cnt = 32'hFFFFFFFF;
        check("cnt_preload", retire_cnt, 32'hFFFFFFFF);
        set_in(K_BUB, 32'd0, 32'd0, 5'd9, 32'd0, 5'd1, 5'd2, 1'b0);
        cycle("wrap_bub");
        set_in(K_ADDIU, 32'd0, 32'hA5A5_0001, 5'd9, 32'h400, 5'd9, 5'd2, 1'b0);
        cycle("wrap_inc");
        check("wrap_zero", retire_cnt, 32'd0);
        set_in(K_BUB, 32'd0, 32'd0, 5'd9, 32'd0, 5'd9, 5'd2, 1'b0);
        cycle("wrap_hold");

        for (int n = 0; n < 300; n++) begin
            k   = $urandom_range(0, 9);
            tgt = 5'($urandom_range(0, 31));
            rs  = ($urandom_range(0, 2) == 0) ? tgt : 5'($urandom_range(0, 31));
            rt  = ($urandom_range(0, 3) == 0) ? tgt : 5'($urandom_range(0, 31));
            set_in(k, $urandom(), $urandom(), tgt, $urandom(), rs, rt,
                   $urandom_range(0, 49) == 0);
            cycle("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
